// File: rtl/demux32x4_reg.sv
// demux32x4_reg: registered 1-to-4 distributor for 32-bit words.
// Each channel has a one-entry holding register with its own valid/ready handshake.
module demux32x4_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] X,
  input  logic [1:0]  S,
  input  logic        AUTO,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Y3,
  output logic [31:0] Y2,
  output logic [31:0] Y1,
  output logic [31:0] Y0,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [1:0]  ptr
);

  logic [1:0]  tgt;
  logic [3:0]  tgt_oh;
  logic        acc;
  logic [31:0] y_q [4];
  logic [31:0] y_d [4];
  logic [3:0]  vld_q;
  logic [3:0]  vld_d;
  logic [1:0]  ptr_q;
  logic [1:0]  ptr_d;

  // Pick the target channel and decide whether the word is taken now.
  always_comb begin
    tgt      = AUTO ? ptr_q : S;
    tgt_oh   = 4'b0001 << tgt;
    in_ready = ~vld_q[tgt] | out_ready[tgt];
    acc      = in_valid & in_ready;
  end

  // Per-channel load/drain; a load wins over a same-cycle drain.
  always_comb begin
    vld_d = vld_q;
    y_d   = y_q;
    for (int k = 0; k < 4; k++) begin
      if (acc && tgt_oh[k]) begin
        vld_d[k] = 1'b1;
        y_d[k]   = X;
      end else if (vld_q[k] && out_ready[k]) begin
        vld_d[k] = 1'b0;
      end
    end
  end

  // Round-robin pointer advances only on a round-robin accept.
  always_comb begin
    ptr_d = ptr_q;
    if (acc && AUTO)
      ptr_d = ptr_q + 2'd1;
  end

  // State registers; reset drops every held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 4'b0000;
      ptr_q <= 2'b00;
      for (int k = 0; k < 4; k++)
        y_q[k] <= 32'h0;
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      for (int k = 0; k < 4; k++)
        y_q[k] <= y_d[k];
    end
  end

  assign Y0        = y_q[0];
  assign Y1        = y_q[1];
  assign Y2        = y_q[2];
  assign Y3        = y_q[3];
  assign out_valid = vld_q;
  assign ptr       = ptr_q;

endmodule

// File: doc/demux32x4_reg.md
# demux32x4_reg

Registered 1-to-4 distributor for 32-bit words: the write-side counterpart of the four-way 32-bit selector. One upstream valid/ready stream is routed to one of four downstream channels, chosen by an explicit 2-bit select or by an internal round-robin pointer. Each channel owns a one-entry holding register with its own valid/ready handshake, so a stalled channel never blocks traffic bound for the others. It sits between a single producer, such as a register-file write port or an ALU result bus, and four independent consumers.

## Interface
- No parameters; data width is fixed at 32, channel count at 4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- X  in  32  input data word.
- S  in  2  target channel when AUTO=0; ignored when AUTO=1.
- AUTO  in  1  1 selects round-robin distribution, 0 selects fixed S.
- in_valid  in  1  X is valid this cycle.
- in_ready  out  1  block accepts X this cycle (combinational).
- Y3, Y2, Y1, Y0  out  32 each  channel holding-register data.
- out_valid  out  4  bit k set means Yk holds an undelivered word.
- out_ready  in  4  bit k set means consumer k takes Yk this cycle.
- ptr  out  2  current round-robin pointer.

## Operation
- Target channel t is ptr when AUTO=1, otherwise S.
- in_ready = ~out_valid[t] | out_ready[t]. It depends on the current S, AUTO and out_ready, with no registered lag.
- Accept = in_valid & in_ready. On accept, Yt <= X and out_valid[t] <= 1.
- Per channel k, when no word for k is accepted this cycle: if out_valid[k] & out_ready[k], out_valid[k] <= 0. Yk keeps its value; data is never cleared after delivery.
- If k drains and loads in the same cycle, Yk takes the new X and out_valid[k] stays 1. No bubble and no loss.
- Channels other than t drain independently in the same cycle as an accept.
- Round-robin pointer:
  - ptr <= ptr+1 mod 4 (3 wraps to 0) only on an accept with AUTO=1.
  - With AUTO=0, ptr holds its value.
  - Toggling AUTO never modifies ptr.
- out_ready[k] while out_valid[k]=0 has no effect.
- in_valid=0 never changes any channel except by draining.
- X, S and AUTO are sampled only on the accept edge.
- There is no ordering guarantee across channels, only within a channel.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - out_valid = 4'b0000.
  - Y0..Y3 = 32'h0.
  - ptr = 2'b00.
  - in_ready evaluates to 1, since all channels are empty.
- While rst=1, the accept and drain rules are suppressed and outputs hold their reset values.
- Reset mid-operation discards every held word without a handshake.
- First accept is possible on the first rising edge after rst deasserts.
- Latency: a word accepted at edge n appears on Yt with out_valid[t]=1 after edge n, and can be consumed at edge n+1.
- Throughput: one word per cycle sustained, including to a single channel, as long as that channel's out_ready stays 1.
- Full channel t with out_ready[t]=0 gives in_ready=0. The producer must hold X; nothing is dropped.
- All outputs except in_ready are registered.

## Test plan
- Reset release, AUTO=0, S=2, X=32'hDEADBEEF, in_valid=1 for one cycle, out_ready=0 → next cycle out_valid=4'b0100, Y2=DEADBEEF, Y0/Y1/Y3=0; with S=2 held, in_ready=0.
- AUTO=1, out_ready=4'hF, four back-to-back words 1, 2, 3, 4 → Y0=1, Y1=2, Y2=3, Y3=4 on consecutive cycles. ptr goes 0→1→2→3→0. in_ready stays 1 throughout.
- AUTO=0, S=1, out_ready[1]=1, words A, B, C every cycle → Y1 shows A, B, C on successive cycles with out_valid[1] continuously 1 and no stall (simultaneous drain and load).
- Channel 3 full with out_ready[3]=0 and S=3 → in_ready=0. Switch S=0 in the same run → in_ready=1, word lands in Y0, and Y3 is unchanged.
- AUTO=1, accept two words (ptr=2), switch AUTO=0 and accept one word with S=0, then AUTO=1 → next word goes to channel 2.
- With out_valid=4'b1011 and ptr=3, assert rst mid-cycle → out_valid=0, Y0..Y3=0 and ptr=0 immediately, without waiting for a clock edge.
